// File: rtl/imem_param.sv
// rtl/imem_param.sv - parametrised instruction memory with program-load port, clear sweep and fetch fault flags
module imem_param #(
    parameter int                DATA_W         = 32,
    parameter int                PC_W           = 32,
    parameter int                DEPTH          = 32,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] NOP_WORD       = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PC_W-1:0]          pc,
    input  logic                     fetch_req,
    output logic                     ready,
    output logic [DATA_W-1:0]        instruction,
    output logic                     instr_valid,
    output logic                     misaligned,
    output logic                     out_of_range,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [DATA_W-1:0]        prog_data,
    output logic                     prog_ack
);

    localparam int             AW   = $clog2(DEPTH);
    localparam logic [AW-1:0]  LAST = AW'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [AW-1:0]     clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     fetch_idx;
    logic              fetch_mis;
    logic              fetch_oor;
    logic              write_hit;
    logic [DATA_W-1:0] fetch_word;

    // ready is gated by reset so a held reset never advertises acceptance
    assign ready      = (state == ST_READY) && !reset;
    assign fetch_idx  = pc[AW+1:2];
    assign fetch_mis  = |pc[1:0];
    assign fetch_oor  = |pc[PC_W-1:AW+2];
    assign write_hit  = prog_we && (prog_addr == fetch_idx);
    assign fetch_word = write_hit ? prog_data : mem[fetch_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_CLEAR: if (clr_cnt == LAST) state_next = ST_READY;
            ST_READY: state_next = ST_READY;
            default:  state_next = ST_CLEAR;
        endcase
    end

    // Array carries no reset; the sweep (or an explicit program load) defines its contents
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if (prog_we) begin
                mem[prog_addr] <= prog_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt      <= '0;
            instruction  <= NOP_WORD;
            instr_valid  <= 1'b0;
            misaligned   <= 1'b0;
            out_of_range <= 1'b0;
            prog_ack     <= 1'b0;
        end else begin
            instr_valid  <= 1'b0;
            misaligned   <= 1'b0;
            out_of_range <= 1'b0;
            prog_ack     <= 1'b0;
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + AW'(1);
            end else begin
                prog_ack <= prog_we;
                if (fetch_req) begin
                    instr_valid  <= 1'b1;
                    misaligned   <= fetch_mis;
                    out_of_range <= fetch_oor;
                    instruction  <= (fetch_mis || fetch_oor) ? NOP_WORD : fetch_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_param.sv
// tb/tb_imem_param.sv - scoreboard bench for imem_param (clearing and non-clearing instances)
module tb_imem_param;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, fetch_req, prog_we;
    logic [31:0] pc, prog_data;
    logic [4:0]  prog_addr;
    logic        ready, instr_valid, misaligned, out_of_range, prog_ack;
    logic [31:0] instruction;

    logic        reset_b, fetch_req_b, prog_we_b;
    logic [31:0] pc_b, prog_data_b;
    logic [4:0]  prog_addr_b;
    logic        ready_b, instr_valid_b, misaligned_b, out_of_range_b, prog_ack_b;
    logic [31:0] instruction_b;

    imem_param #(.DATA_W(32), .PC_W(32), .DEPTH(32), .CLEAR_ON_RESET(1'b1), .NOP_WORD(32'h0)) dut (
        .clk(clk), .reset(reset), .pc(pc), .fetch_req(fetch_req), .ready(ready),
        .instruction(instruction), .instr_valid(instr_valid), .misaligned(misaligned),
        .out_of_range(out_of_range), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_ack(prog_ack)
    );

    imem_param #(.DATA_W(32), .PC_W(32), .DEPTH(32), .CLEAR_ON_RESET(1'b0), .NOP_WORD(32'h0)) dut_b (
        .clk(clk), .reset(reset_b), .pc(pc_b), .fetch_req(fetch_req_b), .ready(ready_b),
        .instruction(instruction_b), .instr_valid(instr_valid_b), .misaligned(misaligned_b),
        .out_of_range(out_of_range_b), .prog_we(prog_we_b), .prog_addr(prog_addr_b),
        .prog_data(prog_data_b), .prog_ack(prog_ack_b)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic        mis;
        logic        oor;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int cnt;
        exp_t e;
        reset = 1'b1;
        step();
        step();
        vectors++;
        if ({ready, instr_valid, misaligned, out_of_range, prog_ack} !== 5'b0 || instruction !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: ready/valid/mis/oor/ack=%b instr=%h, need 00000 and 00000000",
                     {ready, instr_valid, misaligned, out_of_range, prog_ack}, instruction);
        end
        reset = 1'b0;
        cnt = 0;
        while (ready !== 1'b1 && cnt < 100) begin
            cnt++;
            step();
        end
        vectors++;
        if (cnt != 32) begin
            miscompares++;
            $display("FAIL clear_duration: ready low for %0d cycles, need 32", cnt);
        end
        pc = 32'h0;
        fetch_req = 1'b1;
        sbq.push_back('{32'h0, 1'b0, 1'b0});
        step();
        fetch_req = 1'b0;
        vectors++;
        if (instr_valid !== 1'b1 || sbq.size() == 0) begin
            miscompares++;
            $display("FAIL clear_fetch_valid: instr_valid=%b, need 1", instr_valid);
        end else begin
            e = sbq.pop_front();
            vectors++;
            if ({instruction, misaligned, out_of_range} !== e) begin
                miscompares++;
                $display("FAIL clear_fetch_data: got %h/%b/%b, need %h/%b/%b",
                         instruction, misaligned, out_of_range, e.instr, e.mis, e.oor);
            end
        end
    endtask

    task automatic test_program_fetch();
        logic [4:0]  addrs [3];
        logic [31:0] words [3];
        logic [31:0] pcs   [3];
        exp_t e;
        addrs = '{5'd0, 5'd5, 5'd31};
        words = '{32'h02328020, 32'h8C100004, 32'hA5A5_0F0F};
        pcs   = '{32'h0, 32'h14, 32'h7C};
        for (int i = 0; i < 3; i++) begin
            prog_we = 1'b1;
            prog_addr = addrs[i];
            prog_data = words[i];
            step();
            vectors++;
            if (prog_ack !== 1'b1) begin
                miscompares++;
                $display("FAIL prog_ack_%0d: prog_ack=%b, need 1", i, prog_ack);
            end
        end
        prog_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc = pcs[i];
            fetch_req = 1'b1;
            sbq.push_back('{words[i], 1'b0, 1'b0});
            step();
            vectors++;
            if (instr_valid !== 1'b1 || sbq.size() == 0) begin
                miscompares++;
                $display("FAIL b2b_valid_%0d: instr_valid=%b, need 1", i, instr_valid);
            end else begin
                e = sbq.pop_front();
                vectors++;
                if ({instruction, misaligned, out_of_range} !== e) begin
                    miscompares++;
                    $display("FAIL b2b_data_%0d: got %h/%b/%b, need %h/%b/%b",
                             i, instruction, misaligned, out_of_range, e.instr, e.mis, e.oor);
                end
            end
        end
        fetch_req = 1'b0;
        step();
        vectors++;
        if (instr_valid !== 1'b0 || prog_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_pulse: instr_valid=%b prog_ack=%b, need 0 0", instr_valid, prog_ack);
        end
    endtask

    task automatic test_faults();
        logic [31:0] pcs   [5];
        logic [1:0]  flags [5];
        exp_t e;
        pcs   = '{32'h6, 32'h16, 32'h80, 32'h82, 32'h4000_0000};
        flags = '{2'b10, 2'b10, 2'b01, 2'b11, 2'b01};
        for (int i = 0; i < 5; i++) begin
            pc = pcs[i];
            fetch_req = 1'b1;
            sbq.push_back('{32'h0, flags[i][1], flags[i][0]});
            step();
            vectors++;
            if (instr_valid !== 1'b1 || sbq.size() == 0) begin
                miscompares++;
                $display("FAIL fault_valid_%0d: instr_valid=%b, need 1", i, instr_valid);
            end else begin
                e = sbq.pop_front();
                vectors++;
                if ({instruction, misaligned, out_of_range} !== e) begin
                    miscompares++;
                    $display("FAIL fault_pc_%h: got %h/%b/%b, need %h/%b/%b",
                             pcs[i], instruction, misaligned, out_of_range, e.instr, e.mis, e.oor);
                end
            end
        end
        fetch_req = 1'b0;
    endtask

    task automatic test_collision();
        exp_t e;
        prog_we = 1'b1;
        prog_addr = 5'd3;
        prog_data = 32'hDEADBEEF;
        pc = 32'hC;
        fetch_req = 1'b1;
        sbq.push_back('{32'hDEADBEEF, 1'b0, 1'b0});
        step();
        prog_we = 1'b0;
        fetch_req = 1'b0;
        vectors++;
        if (prog_ack !== 1'b1 || instr_valid !== 1'b1 || sbq.size() == 0) begin
            miscompares++;
            $display("FAIL collision_handshake: prog_ack=%b instr_valid=%b, need 1 1", prog_ack, instr_valid);
        end else begin
            e = sbq.pop_front();
            vectors++;
            if ({instruction, misaligned, out_of_range} !== e) begin
                miscompares++;
                $display("FAIL collision_data: got %h, need %h", instruction, e.instr);
            end
        end
        step();
        vectors++;
        if (instr_valid !== 1'b0 || instruction !== 32'hDEADBEEF || misaligned !== 1'b0 || out_of_range !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_last: valid=%b instr=%h flags=%b%b, need 0 deadbeef 00",
                     instr_valid, instruction, misaligned, out_of_range);
        end
    endtask

    task automatic test_reset_mid_clear();
        int   cnt;
        logic seen;
        exp_t e;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        cnt = 0;
        seen = 1'b0;
        fetch_req = 1'b1;
        pc = 32'h8;
        while (ready !== 1'b1 && cnt < 100) begin
            cnt++;
            prog_we   = (cnt == 20);
            prog_addr = 5'd3;
            prog_data = 32'h12345678;
            step();
            if (prog_ack === 1'b1 || instr_valid === 1'b1) seen = 1'b1;
        end
        prog_we = 1'b0;
        fetch_req = 1'b0;
        vectors++;
        if (cnt != 32) begin
            miscompares++;
            $display("FAIL restart_duration: ready low for %0d cycles, need 32", cnt);
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_ignores_requests: ack/valid seen=%b, need 0", seen);
        end
        pc = 32'hC;
        fetch_req = 1'b1;
        sbq.push_back('{32'h0, 1'b0, 1'b0});
        step();
        fetch_req = 1'b0;
        vectors++;
        if (instr_valid !== 1'b1 || sbq.size() == 0) begin
            miscompares++;
            $display("FAIL restart_fetch_valid: instr_valid=%b, need 1", instr_valid);
        end else begin
            e = sbq.pop_front();
            vectors++;
            if ({instruction, misaligned, out_of_range} !== e) begin
                miscompares++;
                $display("FAIL restart_fetch_data: got %h, need %h", instruction, e.instr);
            end
        end
    endtask

    task automatic test_no_clear();
        exp_t e;
        reset_b = 1'b1;
        step();
        reset_b = 1'b0;
        #1;
        vectors++;
        if (ready_b !== 1'b1) begin
            miscompares++;
            $display("FAIL noclr_ready_initial: ready=%b, need 1", ready_b);
        end
        prog_we_b = 1'b1;
        prog_addr_b = 5'd7;
        prog_data_b = 32'h10200003;
        step();
        prog_we_b = 1'b0;
        vectors++;
        if (prog_ack_b !== 1'b1) begin
            miscompares++;
            $display("FAIL noclr_prog_ack: prog_ack=%b, need 1", prog_ack_b);
        end
        reset_b = 1'b1;
        step();
        vectors++;
        if (ready_b !== 1'b0 || prog_ack_b !== 1'b0) begin
            miscompares++;
            $display("FAIL noclr_in_reset: ready=%b prog_ack=%b, need 0 0", ready_b, prog_ack_b);
        end
        reset_b = 1'b0;
        #1;
        vectors++;
        if (ready_b !== 1'b1) begin
            miscompares++;
            $display("FAIL noclr_ready_after_reset: ready=%b, need 1", ready_b);
        end
        pc_b = 32'h1C;
        fetch_req_b = 1'b1;
        sbq.push_back('{32'h10200003, 1'b0, 1'b0});
        step();
        fetch_req_b = 1'b0;
        vectors++;
        if (instr_valid_b !== 1'b1 || sbq.size() == 0) begin
            miscompares++;
            $display("FAIL noclr_fetch_valid: instr_valid=%b, need 1", instr_valid_b);
        end else begin
            e = sbq.pop_front();
            vectors++;
            if ({instruction_b, misaligned_b, out_of_range_b} !== e) begin
                miscompares++;
                $display("FAIL noclr_fetch_data: got %h, need %h", instruction_b, e.instr);
            end
        end
    endtask

    initial begin
        reset = 1'b1; fetch_req = 1'b0; prog_we = 1'b0;
        pc = '0; prog_addr = '0; prog_data = '0;
        reset_b = 1'b1; fetch_req_b = 1'b0; prog_we_b = 1'b0;
        pc_b = '0; prog_addr_b = '0; prog_data_b = '0;
        @(negedge clk);
        test_reset();
        test_program_fetch();
        test_faults();
        test_collision();
        test_reset_mid_clear();
        test_no_clear();
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, need 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
